trigger_capture: RTL and testbench

Sample acquisition stage directly upstream of the on-screen waveform renderer. It takes the 8-bit sample stream, detects a level/edge trigger and records 256 samples around the trigger point, with a programmable pre-trigger section. It then publishes the record as a stable `data_display[0:255]` array on a frame boundary, so the renderer never draws a partially updated trace.

---
 rtl/trigger_capture.sv | 240 ++++++++++++++++++++++++
 tb/tb_trigger_capture.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_capture.sv
// trigger_capture
//
// Acquisition stage in front of the waveform renderer. Samples are written
// into a 256-entry circular capture buffer. A level crossing (rising or
// falling) or an auto-mode timeout marks the trigger sample. After the
// post-trigger section is filled, the record waits for the next
// frame_start. It is then copied in a single cycle into data_display, so
// the renderer only ever sees complete traces.
//
// Parameters
//   PRE           pre-trigger samples (0..255); the trigger sample lands at data_display[PRE]
//   AUTO_TIMEOUT  accepted ARMED samples before a forced trigger in auto mode (>= 1)
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active low
//   sample        8-bit input sample, consumed when sample_valid is high
//   sample_valid  sample qualifier
//   trig_level    trigger threshold (unsigned)
//   trig_falling  0 = rising-edge trigger, 1 = falling-edge trigger
//   auto_mode     force a trigger after AUTO_TIMEOUT samples in ARMED
//   run           1 = acquire continuously, 0 = stop and hold the display
//   frame_start   one-cycle pulse at the start of vertical blanking
//   data_display  published record; index 0 = oldest sample
//   armed         state is ARMED
//   triggered     state is POST or DONE
//   frame_ready   one-cycle pulse after data_display has been updated
module trigger_capture #(
  parameter int PRE          = 32,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  input  logic [7:0] trig_level,
  input  logic       trig_falling,
  input  logic       auto_mode,
  input  logic       run,
  input  logic       frame_start,
  output logic [7:0] data_display [0:255],
  output logic       armed,
  output logic       triggered,
  output logic       frame_ready
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] PRETRIG = 3'd1;
  localparam logic [2:0] ARMED   = 3'd2;
  localparam logic [2:0] POST    = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam logic [7:0] PRE_B      = 8'(PRE);
  localparam logic [7:0] PRE_LAST   = 8'(PRE - 1);
  localparam int         POST_LEN   = 255 - PRE;
  localparam logic [7:0] POST_LAST  = 8'(POST_LEN - 1);
  localparam int         TO_W       = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(AUTO_TIMEOUT - 1);

  logic [2:0]      state_reg,    state_next;
  logic [7:0]      wr_ptr_reg,   wr_ptr_next;
  logic [7:0]      trig_ptr_reg, trig_ptr_next;
  logic [7:0]      prev_reg,     prev_next;
  logic            prev_ok_reg,  prev_ok_next;
  logic [7:0]      cnt_reg,      cnt_next;
  logic [TO_W-1:0] to_cnt_reg,   to_cnt_next;
  logic            armed_reg;
  logic            triggered_reg;
  logic            frame_ready_reg;

  logic            capturing;
  logic            accept;
  logic            edge_hit;
  logic            timeout_hit;
  logic            publish;

  // Every entry is read in parallel on publish, so the capture buffer is a
  // register file rather than a single-port RAM.
  logic [7:0]      cap [0:255];
  logic [7:0]      rd_base;
  logic [7:0]      pub_val [0:255];

  assign capturing = (state_reg == PRETRIG) || (state_reg == ARMED) || (state_reg == POST);
  // Dropping run aborts the capture, so the sample of that cycle is not taken.
  assign accept    = capturing && run && sample_valid;

  assign edge_hit = trig_falling
                  ? (prev_ok_reg && (prev_reg > trig_level) && (sample <= trig_level))
                  : (prev_ok_reg && (prev_reg < trig_level) && (sample >= trig_level));

  // to_cnt_reg holds the number of ARMED samples already seen; this sample is
  // the AUTO_TIMEOUT-th when the count has reached AUTO_TIMEOUT-1.
  assign timeout_hit = auto_mode && (to_cnt_reg >= TO_LAST);

  always_comb begin
    state_next    = state_reg;
    wr_ptr_next   = wr_ptr_reg;
    trig_ptr_next = trig_ptr_reg;
    prev_next     = prev_reg;
    prev_ok_next  = prev_ok_reg;
    cnt_next      = cnt_reg;
    to_cnt_next   = to_cnt_reg;
    publish       = 1'b0;

    if (accept) begin
      wr_ptr_next  = wr_ptr_reg + 8'd1;
      prev_next    = sample;
      prev_ok_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (run) begin
          state_next   = PRETRIG;
          cnt_next     = '0;
          to_cnt_next  = '0;
          prev_ok_next = 1'b0;
        end
      end

      PRETRIG: begin
        if (!run) begin
          state_next = IDLE;
        end else if (PRE == 0) begin
          state_next  = ARMED;
          to_cnt_next = '0;
        end else if (accept) begin
          if (cnt_reg == PRE_LAST) begin
            state_next  = ARMED;
            to_cnt_next = '0;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end

      ARMED: begin
        if (!run) begin
          state_next = IDLE;
        end else if (accept) begin
          if (edge_hit || timeout_hit) begin
            trig_ptr_next = wr_ptr_reg;
            cnt_next      = '0;
            // With PRE = 255 the trigger sample is also the last one.
            state_next    = (POST_LEN == 0) ? DONE : POST;
          end else if (to_cnt_reg != TO_LAST) begin
            // Saturate so a late switch to auto mode still forces a trigger.
            to_cnt_next = to_cnt_reg + 1'b1;
          end
        end
      end

      POST: begin
        if (!run) begin
          state_next = IDLE;
        end else if (accept) begin
          if (cnt_reg == POST_LAST) begin
            state_next = DONE;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end

      DONE: begin
        if (frame_start) begin
          publish = 1'b1;
          if (run) begin
            state_next   = PRETRIG;
            cnt_next     = '0;
            to_cnt_next  = '0;
            prev_ok_next = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      wr_ptr_reg      <= '0;
      trig_ptr_reg    <= '0;
      prev_reg        <= '0;
      prev_ok_reg     <= 1'b0;
      cnt_reg         <= '0;
      to_cnt_reg      <= '0;
      armed_reg       <= 1'b0;
      triggered_reg   <= 1'b0;
      frame_ready_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wr_ptr_reg      <= wr_ptr_next;
      trig_ptr_reg    <= trig_ptr_next;
      prev_reg        <= prev_next;
      prev_ok_reg     <= prev_ok_next;
      cnt_reg         <= cnt_next;
      to_cnt_reg      <= to_cnt_next;
      armed_reg       <= (state_next == ARMED);
      triggered_reg   <= (state_next == POST) || (state_next == DONE);
      frame_ready_reg <= publish;
    end
  end

  // Buffer contents are meaningless until a full record is written, so they
  // carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap[wr_ptr_reg] <= sample;
    end
  end

  // Oldest sample of the record sits PRE entries before the trigger sample.
  assign rd_base = trig_ptr_reg - PRE_B;

  for (genvar gi = 0; gi < 256; gi++) begin : g_pub
    assign pub_val[gi] = cap[rd_base + 8'(gi)];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) begin
        data_display[i] <= '0;
      end
    end else if (publish) begin
      for (int i = 0; i < 256; i++) begin
        data_display[i] <= pub_val[i];
      end
    end
  end

  assign armed       = armed_reg;
  assign triggered   = triggered_reg;
  assign frame_ready = frame_ready_reg;

endmodule

// File: tb/tb_trigger_capture.sv
module tb_trigger_capture;

  localparam int PRE          = 32;
  localparam int AUTO_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sample = '0;
  logic       sample_valid = 1'b0;
  logic [7:0] trig_level = '0;
  logic       trig_falling = 1'b0;
  logic       auto_mode = 1'b0;
  logic       run = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] data_display [0:255];
  logic       armed;
  logic       triggered;
  logic       frame_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trigger_capture #(
    .PRE(PRE),
    .AUTO_TIMEOUT(AUTO_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample(sample),
    .sample_valid(sample_valid),
    .trig_level(trig_level),
    .trig_falling(trig_falling),
    .auto_mode(auto_mode),
    .run(run),
    .frame_start(frame_start),
    .data_display(data_display),
    .armed(armed),
    .triggered(triggered),
    .frame_ready(frame_ready)
  );

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    sample       = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    run = 1'b0;
    repeat (3) tick();
    checks++;
    if (armed !== 1'b0 || triggered !== 1'b0 || frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: armed=%b triggered=%b frame_ready=%b expected 0 0 0", armed, triggered, frame_ready);
    end
    checks++;
    if (data_display[0] !== 8'd0 || data_display[255] !== 8'd0) begin
      errors++;
      $display("FAIL reset_display: d[0]=%0d d[255]=%0d expected 0 0", data_display[0], data_display[255]);
    end
    rst = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_rising_ramp();
    trig_level   = 8'd128;
    trig_falling = 1'b0;
    auto_mode    = 1'b0;
    run          = 1'b1;
    tick();
    for (int k = 0; k < 352; k++) begin
      push(8'(k));
      if (k == 30) begin
        checks++;
        if (armed !== 1'b0) begin
          errors++;
          $display("FAIL ramp_armed_early: armed=%b expected 0", armed);
        end
      end
      if (k == 31) begin
        checks++;
        if (armed !== 1'b1) begin
          errors++;
          $display("FAIL ramp_armed: armed=%b expected 1", armed);
        end
      end
      if (k == 127) begin
        checks++;
        if (triggered !== 1'b0) begin
          errors++;
          $display("FAIL ramp_trig_early: triggered=%b expected 0", triggered);
        end
      end
      if (k == 128) begin
        checks++;
        if (triggered !== 1'b1 || armed !== 1'b0) begin
          errors++;
          $display("FAIL ramp_trig: triggered=%b armed=%b expected 1 0", triggered, armed);
        end
      end
    end
    // Extra samples after DONE must not reach the record.
    repeat (5) push(8'hEE);
    checks++;
    if (data_display[32] !== 8'd0) begin
      errors++;
      $display("FAIL ramp_unpublished: d[32]=%0d expected 0", data_display[32]);
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++;
    if (frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL ramp_frame_ready: got %b expected 1", frame_ready);
    end
    checks++;
    if (data_display[32] !== 8'd128 || data_display[0] !== 8'd96 || data_display[255] !== 8'd95) begin
      errors++;
      $display("FAIL ramp_record: d[0]=%0d d[32]=%0d d[255]=%0d expected 96 128 95",
               data_display[0], data_display[32], data_display[255]);
    end
    checks++;
    if (triggered !== 1'b0) begin
      errors++;
      $display("FAIL ramp_restart: triggered=%b expected 0", triggered);
    end
    tick();
    checks++;
    if (frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL ramp_frame_ready_pulse: got %b expected 0", frame_ready);
    end
    $display("test_rising_ramp: d[0]=%0d d[32]=%0d d[255]=%0d", data_display[0], data_display[32], data_display[255]);
  endtask

  task automatic test_falling_ramp();
    trig_falling = 1'b1;
    trig_level   = 8'd50;
    for (int k = 0; k < 429; k++) begin
      push(8'(255 - (k % 256)));
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++;
    if (frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL fall_frame_ready: got %b expected 1", frame_ready);
    end
    checks++;
    if (data_display[32] !== 8'd50 || data_display[31] !== 8'd51) begin
      errors++;
      $display("FAIL fall_trigger_point: d[31]=%0d d[32]=%0d expected 51 50", data_display[31], data_display[32]);
    end
    checks++;
    if (data_display[0] !== 8'd82 || data_display[255] !== 8'd83) begin
      errors++;
      $display("FAIL fall_ends: d[0]=%0d d[255]=%0d expected 82 83", data_display[0], data_display[255]);
    end
    $display("test_falling_ramp: d[31]=%0d d[32]=%0d", data_display[31], data_display[32]);
  endtask

  task automatic test_auto();
    run = 1'b0;
    tick();
    trig_falling = 1'b0;
    trig_level   = 8'd128;
    auto_mode    = 1'b1;
    run          = 1'b1;
    tick();
    for (int k = 0; k < 271; k++) begin
      push(8'd10);
      if (k == 46) begin
        checks++;
        if (triggered !== 1'b0) begin
          errors++;
          $display("FAIL auto_trig_early: triggered=%b expected 0", triggered);
        end
      end
      if (k == 47) begin
        checks++;
        if (triggered !== 1'b1) begin
          errors++;
          $display("FAIL auto_trig: triggered=%b expected 1", triggered);
        end
      end
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (data_display[i] !== 8'd10) begin
        errors++;
        $display("FAIL auto_record[%0d]: got %0d expected 10", i, data_display[i]);
      end
    end
    $display("test_auto: forced trigger record published");

    run = 1'b0;
    tick();
    auto_mode = 1'b0;
    run       = 1'b1;
    tick();
    for (int k = 0; k < 300; k++) begin
      push(8'd10);
      if (k % 50 == 49) begin
        checks++;
        if (triggered !== 1'b0) begin
          errors++;
          $display("FAIL no_auto_trig at %0d: triggered=%b expected 0", k, triggered);
        end
      end
    end
    checks++;
    if (armed !== 1'b1) begin
      errors++;
      $display("FAIL no_auto_armed: armed=%b expected 1", armed);
    end
    $display("test_auto: no trigger without auto_mode");
  endtask

  task automatic test_frame_wait();
    logic seen_ready;
    trig_level = 8'd128;
    // frame_start while ARMED is ignored.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++;
    if (frame_ready !== 1'b0 || armed !== 1'b1) begin
      errors++;
      $display("FAIL armed_frame_start: frame_ready=%b armed=%b expected 0 1", frame_ready, armed);
    end
    for (int k = 0; k < 352; k++) begin
      // Pulse coincides with the last POST sample: no publish yet.
      if (k == 351) frame_start = 1'b1;
      push(8'(k));
      frame_start = 1'b0;
    end
    checks++;
    if (triggered !== 1'b1 || frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL last_post_frame: triggered=%b frame_ready=%b expected 1 0", triggered, frame_ready);
    end
    seen_ready = 1'b0;
    sample = 8'hEE;
    sample_valid = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (frame_ready === 1'b1) seen_ready = 1'b1;
    end
    sample_valid = 1'b0;
    checks++;
    if (seen_ready !== 1'b0 || triggered !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: seen_ready=%b triggered=%b expected 0 1", seen_ready, triggered);
    end
    checks++;
    if (data_display[32] !== 8'd10) begin
      errors++;
      $display("FAIL wait_display_held: d[32]=%0d expected 10", data_display[32]);
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++;
    if (frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_frame_ready: got %b expected 1", frame_ready);
    end
    checks++;
    if (data_display[32] !== 8'd128 || data_display[0] !== 8'd96 || data_display[255] !== 8'd95) begin
      errors++;
      $display("FAIL wait_record: d[0]=%0d d[32]=%0d d[255]=%0d expected 96 128 95",
               data_display[0], data_display[32], data_display[255]);
    end
    $display("test_frame_wait: published after long wait, d[32]=%0d", data_display[32]);
  endtask

  task automatic test_reset_mid_post();
    trig_level = 8'd128;
    for (int k = 0; k < 151; k++) begin
      push(8'(k));
    end
    checks++;
    if (triggered !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_post: triggered=%b expected 1", triggered);
    end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (armed !== 1'b0 || triggered !== 1'b0 || frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_flags: armed=%b triggered=%b frame_ready=%b expected 0 0 0", armed, triggered, frame_ready);
    end
    checks++;
    if (data_display[32] !== 8'd0 || data_display[0] !== 8'd0) begin
      errors++;
      $display("FAIL async_reset_display: d[0]=%0d d[32]=%0d expected 0 0", data_display[0], data_display[32]);
    end
    tick();
    rst = 1'b1;
    tick();
    trig_level = 8'd200;
    for (int k = 0; k < 424; k++) begin
      push(8'(k));
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++;
    if (data_display[32] !== 8'd200 || data_display[0] !== 8'd168 || data_display[255] !== 8'd167) begin
      errors++;
      $display("FAIL post_reset_record: d[0]=%0d d[32]=%0d d[255]=%0d expected 168 200 167",
               data_display[0], data_display[32], data_display[255]);
    end
    $display("test_reset_mid_post: d[32]=%0d after recapture", data_display[32]);
  endtask

  task automatic test_run_drop();
    for (int k = 0; k < 40; k++) begin
      push(8'd10);
    end
    checks++;
    if (armed !== 1'b1) begin
      errors++;
      $display("FAIL drop_armed_before: armed=%b expected 1", armed);
    end
    run = 1'b0;
    tick();
    checks++;
    if (armed !== 1'b0 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle: armed=%b triggered=%b expected 0 0", armed, triggered);
    end
    checks++;
    if (data_display[32] !== 8'd200) begin
      errors++;
      $display("FAIL drop_display_held: d[32]=%0d expected 200", data_display[32]);
    end
    repeat (3) tick();
    run = 1'b1;
    tick();
    for (int k = 0; k < 32; k++) begin
      push(8'd10);
      if (k == 30) begin
        checks++;
        if (armed !== 1'b0) begin
          errors++;
          $display("FAIL restart_armed_early: armed=%b expected 0", armed);
        end
      end
      if (k == 31) begin
        checks++;
        if (armed !== 1'b1) begin
          errors++;
          $display("FAIL restart_armed: armed=%b expected 1", armed);
        end
      end
    end
    $display("test_run_drop: fresh pre-trigger after run restored");
  endtask

  initial begin
    test_reset();
    test_rising_ramp();
    test_falling_ramp();
    test_auto();
    test_frame_wait();
    test_reset_mid_post();
    test_run_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
